ov5640_iic_slave: RTL and testbench
===================================

OV5640_IIC_SLAVE -- requirements
Module: ov5640_iic_slave

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h3C, 7-bit target address (write byte 0x78, read byte 0x79).
REQ-002 SHALL have port sclk  input  1  system clock; all logic on posedge.
REQ-003 SHALL have port s_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port iic_clk  input  1  bus SCL, sampled only, never driven.
REQ-005 SHALL have port iic_sda  inout  1  bus SDA; driven 1'b0 only, otherwise 1'bz (open-drain).
REQ-006 SHALL have port reg_addr  output  16  current register address pointer.
REQ-007 SHALL have port reg_wdata  output  8  received write data byte.
REQ-008 SHALL have port reg_we  output  1  one-cycle write strobe; reg_addr/reg_wdata valid in the same cycle.
REQ-009 SHALL have port reg_re  output  1  one-cycle read request for reg_addr.
REQ-010 SHALL have port reg_rdata  input  8  read data; valid 2 sclk cycles after reg_re.
REQ-011 SHALL have port busy  output  1  high from START until STOP or abort.

Function
REQ-012 SHALL pass iic_clk and iic_sda through 2-flop synchronisers, plus one history flop each for edge detection.
REQ-013 SHALL operate correctly when each SCL half-period is at least 8 sclk cycles; behaviour at faster SCL is undefined.
REQ-014 SHALL detect START as a synchronised SDA falling edge while SCL is high, and STOP as a synchronised SDA rising edge while SCL is high.
REQ-015 SHALL shift data in MSB-first on SCL rising edges, and change its own SDA drive only on SCL falling edges.
REQ-016 SHALL use FSM states IDLE, DEV, ACK_DEV, ADDR_H, ACK_H, ADDR_L, ACK_L, WDATA, ACK_W, RDATA, MACK, with a 3-bit bit counter.
REQ-017 IDLE->DEV on START; a START in any state (repeated START) SHALL restart DEV and clear the bit counter.
REQ-018 DEV: after 8 bits, SHALL compare bits[7:1] to DEV_ADDR; on match go to ACK_DEV and drive SDA low from the next SCL fall to the following SCL fall; on mismatch release SDA and go to IDLE.
REQ-019 On write (R/W=0), ACK_DEV SHALL lead to ADDR_H -> ACK_H -> ADDR_L -> ACK_L, loading reg_addr[15:8] and then reg_addr[7:0], and ACKing each byte.
REQ-020 After ACK_L, each further byte in WDATA SHALL be ACKed in ACK_W, pulse reg_we once on the 8th SCL rising edge, and then increment reg_addr (wraps 16'hFFFF->16'h0000).
REQ-021 On read (R/W=1), SHALL pulse reg_re on the 8th SCL rise of DEV, latch reg_rdata 2 cycles later, and shift it out MSB-first in RDATA: drive 0 for '0' bits, release for '1' bits.
REQ-022 After each read byte, SHALL release SDA in MACK and sample the master's bit on SCL rise.
REQ-023 In MACK, master ACK (0) SHALL increment reg_addr, pulse reg_re and continue RDATA; master NACK (1) SHALL go to IDLE-wait with SDA released.
REQ-024 STOP in any state SHALL return to IDLE, release SDA and drop busy; reg_addr SHALL be retained across STOP so that the STOP/START address-then-read sequence works.
REQ-025 STOP or START mid-byte SHALL discard the partial byte and SHALL NOT pulse reg_we.
REQ-026 SDA SHALL never be driven low while SCL is high, except when holding a data/ACK bit that was set at the preceding SCL fall.

Reset
REQ-027 On s_rst_n low: state IDLE, SDA released, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, synchronisers=1.
REQ-028 Reset mid-transaction SHALL release SDA in the same cycle; no strobe SHALL be issued afterwards until a new START.

Structure
REQ-029 FSM state encoding and DEV_ADDR default SHALL live in shared package ov5640_iic_pkg.
REQ-030 SHALL instantiate one sub-module, ov5640_iic_sync (2-flop synchroniser plus edge detect), once each for SCL and SDA.

Verification
REQ-031 Write 0x78,0x30,0x08,0x82 then STOP -> ACK on all 4 bytes; reg_we one pulse with reg_addr=0x3008 and reg_wdata=0x82.
REQ-032 Write 0x78,0x38,0x00,0x11,0x22 -> reg_we at 0x3800 with 0x11, then at 0x3801 with 0x22.
REQ-033 Write 0x78,0x30,0x0A; STOP; START; 0x79; reg_rdata=0x56; master NACK -> reg_re at 0x300A; SDA returns 0x56; bus released.
REQ-034 Address byte 0x7A -> SDA stays released at the 9th clock; no reg_we or reg_re; busy low after STOP.
REQ-035 STOP after 4 bits of a data byte -> no reg_we; state IDLE; next transaction succeeds.
REQ-036 s_rst_n asserted while slave drives ACK -> iic_sda goes to z immediately; all outputs at reset values.

Source files
------------

// File: rtl/ov5640_iic_pkg.sv
// ---------------------------------------------------------------------------
// ov5640_iic_pkg
// Shared definitions for the OV5640-style I2C register slave: the default
// 7-bit target address and the protocol FSM state encoding.
// ---------------------------------------------------------------------------
package ov5640_iic_pkg;

  // 7-bit target address: write byte 0x78, read byte 0x79
  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h3C;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    DEV     = 4'd1,
    ACK_DEV = 4'd2,
    ADDR_H  = 4'd3,
    ACK_H   = 4'd4,
    ADDR_L  = 4'd5,
    ACK_L   = 4'd6,
    WDATA   = 4'd7,
    ACK_W   = 4'd8,
    RDATA   = 4'd9,
    MACK    = 4'd10
  } iic_state_e;

endpackage

// File: rtl/ov5640_iic_sync.sv
// ---------------------------------------------------------------------------
// ov5640_iic_sync
// Two-flop synchroniser for one asynchronous bus line plus a history flop
// used to produce single-cycle edge pulses in the sclk domain.
// Ports:
//   sclk    - system clock
//   s_rst_n - asynchronous active-low reset (all flops reset to 1, the
//             idle level of an I2C line)
//   d_i     - raw asynchronous line
//   level_o - synchronised level
//   rise_o  - one-cycle pulse on a synchronised 0->1 transition
//   fall_o  - one-cycle pulse on a synchronised 1->0 transition
// ---------------------------------------------------------------------------
module ov5640_iic_sync
  import ov5640_iic_pkg::*;
(
  input  logic sclk,
  input  logic s_rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic hist_q;

  // Synchroniser chain and edge-detect history
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      hist_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~hist_q;
  assign fall_o  = ~sync_q & hist_q;

endmodule

// File: rtl/ov5640_iic_slave.sv
// ---------------------------------------------------------------------------
// ov5640_iic_slave
// I2C slave with a 16-bit register address pointer, in the SCCB/OV5640
// style: [dev W][addr hi][addr lo][data...] for writes, and
// [dev R][data...] for reads starting at the retained pointer.
// Ports:
//   sclk, s_rst_n - system clock, asynchronous active-low reset
//   iic_clk       - bus SCL (sampled only)
//   iic_sda       - bus SDA, open-drain (driven 0 or released)
//   reg_addr      - register address pointer
//   reg_wdata     - last received write byte
//   reg_we        - one-cycle write strobe for reg_addr/reg_wdata
//   reg_re        - one-cycle read request for reg_addr
//   reg_rdata     - read data, valid 2 sclk cycles after reg_re
//   busy          - high from START until STOP or reset
// ---------------------------------------------------------------------------
module ov5640_iic_slave
  import ov5640_iic_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT
) (
  input  logic        sclk,
  input  logic        s_rst_n,
  input  logic        iic_clk,
  inout  wire         iic_sda,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [7:0]  reg_rdata,
  output logic        busy
);

  logic scl_lvl_s, scl_rise_s, scl_fall_s;
  logic sda_lvl_s, sda_rise_s, sda_fall_s;
  logic start_s, stop_s, rx_done_s;
  logic [7:0] rx_byte_s;

  iic_state_e  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        rw_q, rw_d;
  logic        sda_low_q, sda_low_d;
  logic        mack_ok_q, mack_ok_d;
  logic [7:0]  tx_q, tx_d;
  logic [1:0]  re_dly_q, re_dly_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        re_q, re_d;
  logic        busy_q, busy_d;

  ov5640_iic_sync u_sync_scl (
    .sclk    (sclk),
    .s_rst_n (s_rst_n),
    .d_i     (iic_clk),
    .level_o (scl_lvl_s),
    .rise_o  (scl_rise_s),
    .fall_o  (scl_fall_s)
  );

  ov5640_iic_sync u_sync_sda (
    .sclk    (sclk),
    .s_rst_n (s_rst_n),
    .d_i     (iic_sda),
    .level_o (sda_lvl_s),
    .rise_o  (sda_rise_s),
    .fall_o  (sda_fall_s)
  );

  // Both lines share the same synchroniser latency, so SCL level is
  // coherent with the SDA edge.
  assign start_s   = sda_fall_s & scl_lvl_s;
  assign stop_s    = sda_rise_s & scl_lvl_s;
  assign rx_byte_s = {shift_q[6:0], sda_lvl_s};
  assign rx_done_s = scl_rise_s & (bit_cnt_q == 3'd7);

  // State and datapath registers
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      rw_q      <= 1'b0;
      sda_low_q <= 1'b0;
      mack_ok_q <= 1'b0;
      tx_q      <= 8'h00;
      re_dly_q  <= 2'b00;
      addr_q    <= 16'h0000;
      wdata_q   <= 8'h00;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rw_q      <= rw_d;
      sda_low_q <= sda_low_d;
      mack_ok_q <= mack_ok_d;
      tx_q      <= tx_d;
      re_dly_q  <= re_dly_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      busy_q    <= busy_d;
    end
  end

  // Protocol FSM: next state, SDA drive and register-port strobes
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rw_d      = rw_q;
    sda_low_d = sda_low_q;
    mack_ok_d = mack_ok_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    busy_d    = busy_q;
    // reg_rdata is captured two cycles after the read request
    re_dly_d  = {re_dly_q[0], re_q};
    if (re_dly_q[1]) begin
      tx_d = reg_rdata;
    end else begin
      tx_d = tx_q;
    end

    if (start_s) begin
      state_d   = DEV;
      bit_cnt_d = 3'd0;
      busy_d    = 1'b1;
      sda_low_d = 1'b0;
      mack_ok_d = 1'b0;
    end else if (stop_s) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      busy_d    = 1'b0;
      sda_low_d = 1'b0;
      mack_ok_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end

        DEV, ADDR_H, ADDR_L, WDATA: begin
          if (scl_rise_s) begin
            shift_d   = rx_byte_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else begin
            shift_d = shift_q;
          end
          if (rx_done_s) begin
            case (state_q)
              DEV: begin
                if (rx_byte_s[7:1] == DEV_ADDR) begin
                  state_d = ACK_DEV;
                  rw_d    = rx_byte_s[0];
                  re_d    = rx_byte_s[0];
                end else begin
                  state_d = IDLE;
                end
              end
              ADDR_H: begin
                addr_d[15:8] = rx_byte_s;
                state_d      = ACK_H;
              end
              ADDR_L: begin
                addr_d[7:0] = rx_byte_s;
                state_d     = ACK_L;
              end
              WDATA: begin
                wdata_d = rx_byte_s;
                we_d    = 1'b1;
                state_d = ACK_W;
              end
              default: begin
                state_d = IDLE;
              end
            endcase
          end else begin
            state_d = state_q;
          end
        end

        // First fall after the 8th bit pulls SDA low; the next fall
        // releases it and moves on.
        ACK_DEV, ACK_H, ACK_L, ACK_W: begin
          if (scl_fall_s) begin
            if (sda_low_q) begin
              sda_low_d = 1'b0;
              bit_cnt_d = 3'd0;
              case (state_q)
                ACK_DEV: begin
                  if (rw_q) begin
                    state_d   = RDATA;
                    sda_low_d = ~tx_q[7];
                    tx_d      = {tx_q[6:0], 1'b1};
                  end else begin
                    state_d = ADDR_H;
                  end
                end
                ACK_H: begin
                  state_d = ADDR_L;
                end
                ACK_L: begin
                  state_d = WDATA;
                end
                ACK_W: begin
                  state_d = WDATA;
                  addr_d  = addr_q + 16'd1;
                end
                default: begin
                  state_d = IDLE;
                end
              endcase
            end else begin
              sda_low_d = 1'b1;
            end
          end else begin
            state_d = state_q;
          end
        end

        RDATA: begin
          if (scl_fall_s) begin
            sda_low_d = ~tx_q[7];
            tx_d      = {tx_q[6:0], 1'b1};
          end else begin
            sda_low_d = sda_low_q;
          end
          if (scl_rise_s) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d   = MACK;
              mack_ok_d = 1'b0;
            end else begin
              state_d = RDATA;
            end
          end else begin
            state_d = RDATA;
          end
        end

        // First fall releases the last data bit; the master's bit is
        // sampled on the rise; after an ACK the next fall starts a byte.
        MACK: begin
          if (scl_rise_s) begin
            if (!sda_lvl_s) begin
              mack_ok_d = 1'b1;
              addr_d    = addr_q + 16'd1;
              re_d      = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else if (scl_fall_s) begin
            if (mack_ok_q) begin
              state_d   = RDATA;
              mack_ok_d = 1'b0;
              bit_cnt_d = 3'd0;
              sda_low_d = ~tx_q[7];
              tx_d      = {tx_q[6:0], 1'b1};
            end else begin
              sda_low_d = 1'b0;
            end
          end else begin
            state_d = MACK;
          end
        end

        default: begin
          state_d   = IDLE;
          sda_low_d = 1'b0;
        end
      endcase
    end
  end

  assign iic_sda   = sda_low_q ? 1'b0 : 1'bz;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ov5640_iic_slave.sv
`timescale 1ns/1ps
module tb_ov5640_iic_slave;

  logic        sclk = 1'b0;
  logic        s_rst_n;
  logic        scl;
  logic        m_sda;          // 1 = master releases SDA
  wire         sda_bus;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [7:0]  reg_rdata = 8'h00;
  logic [7:0]  rd_p1 = 8'h00;
  logic        busy;

  int h = 10;                  // SCL half period in sclk cycles
  int n_chk = 0;
  int n_pass = 0;

  logic [7:0]  rf  [logic [15:0]];   // register file behind the slave
  logic [7:0]  mdl [logic [15:0]];   // reference model memory
  logic [15:0] mdl_ptr;
  logic [7:0]  wbuf [$];
  logic [23:0] we_log [$];
  logic [23:0] exp_we [$];
  logic [15:0] re_log [$];
  logic [15:0] exp_re [$];

  always #5 sclk = ~sclk;

  pullup (sda_bus);
  assign sda_bus = m_sda ? 1'bz : 1'b0;

  ov5640_iic_slave dut (
    .sclk      (sclk),
    .s_rst_n   (s_rst_n),
    .iic_clk   (scl),
    .iic_sda   (sda_bus),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  function automatic logic [7:0] dflt(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] rf_rd(input logic [15:0] a);
    return rf.exists(a) ? rf[a] : dflt(a);
  endfunction

  function automatic logic [7:0] mdl_rd(input logic [15:0] a);
    return mdl.exists(a) ? mdl[a] : dflt(a);
  endfunction

  // Bus monitor: record strobes and update the register file
  always @(negedge sclk) begin
    if (reg_we) begin
      we_log.push_back({reg_addr, reg_wdata});
      rf[reg_addr] = reg_wdata;
    end
    if (reg_re) re_log.push_back(reg_addr);
  end

  // Register file read port: data valid two cycles after reg_re
  always @(posedge sclk) begin
    if (reg_re) rd_p1 <= rf_rd(reg_addr);
    reg_rdata <= rd_p1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; tick(h / 2);
    scl = 1'b1;   tick(h);
    m_sda = 1'b0; tick(h);
    scl = 1'b0;   tick(h / 2);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(h / 2);
    scl = 1'b1;   tick(h);
    m_sda = 1'b1; tick(h);
  endtask

  task automatic wr_bit(input logic b);
    m_sda = b;  tick(h / 2);
    scl = 1'b1; tick(h);
    scl = 1'b0; tick(h / 2);
  endtask

  task automatic send_chk(input string tag, input logic [7:0] b, input logic exp_ack);
    logic a;
    for (int i = 7; i >= 0; i--) wr_bit(b[i]);
    m_sda = 1'b1; tick(h / 2);
    scl = 1'b1;   tick(h / 2);
    a = sda_bus;  tick(h / 2);
    scl = 1'b0;   tick(h / 2);
    chk(tag, {31'd0, a}, {31'd0, exp_ack});
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic nack);
    b = 8'h00;
    m_sda = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(h / 2);
      scl = 1'b1; tick(h / 2);
      b = {b[6:0], sda_bus}; tick(h / 2);
      scl = 1'b0; tick(h / 2);
    end
    m_sda = nack; tick(h / 2);
    scl = 1'b1;   tick(h);
    scl = 1'b0;   tick(h / 2);
    m_sda = 1'b1;
  endtask

  // Write transaction: address a, data from wbuf (empty = pointer set only)
  task automatic wr_txn(input logic [15:0] a);
    i2c_start();
    chk("busy_on", {31'd0, busy}, 32'd1);
    send_chk("ack_dev", 8'h78, 1'b0);
    send_chk("ack_ah", a[15:8], 1'b0);
    send_chk("ack_al", a[7:0], 1'b0);
    mdl_ptr = a;
    foreach (wbuf[i]) begin
      send_chk("ack_wd", wbuf[i], 1'b0);
      exp_we.push_back({mdl_ptr, wbuf[i]});
      mdl[mdl_ptr] = wbuf[i];
      mdl_ptr = mdl_ptr + 16'd1;
    end
    i2c_stop();
    chk("busy_off", {31'd0, busy}, 32'd0);
  endtask

  // Read transaction of n bytes from the current pointer, NACK on the last
  task automatic rd_txn(input int n);
    logic [7:0] b;
    i2c_start();
    send_chk("ack_rdev", 8'h79, 1'b0);
    for (int i = 0; i < n; i++) begin
      exp_re.push_back(mdl_ptr);
      recv_byte(b, i == n - 1);
      chk("rdata", {24'd0, b}, {24'd0, mdl_rd(mdl_ptr)});
      if (i != n - 1) mdl_ptr = mdl_ptr + 16'd1;
    end
    i2c_stop();
    chk("rd_release", {31'd0, sda_bus}, 32'd1);
    chk("rd_busy_off", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_logs(input string tag);
    chk({tag, "_we_n"}, we_log.size(), exp_we.size());
    for (int i = 0; i < exp_we.size() && i < we_log.size(); i++)
      chk({tag, "_we"}, {8'd0, we_log[i]}, {8'd0, exp_we[i]});
    chk({tag, "_re_n"}, re_log.size(), exp_re.size());
    for (int i = 0; i < exp_re.size() && i < re_log.size(); i++)
      chk({tag, "_re"}, {16'd0, re_log[i]}, {16'd0, exp_re[i]});
    chk({tag, "_ptr"}, {16'd0, reg_addr}, {16'd0, mdl_ptr});
    we_log.delete(); exp_we.delete(); re_log.delete(); exp_re.delete();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] dev_w;
    s_rst_n = 1'b0; scl = 1'b1; m_sda = 1'b1; mdl_ptr = 16'h0000;
    rf[16'h300A]  = 8'h56;
    mdl[16'h300A] = 8'h56;
    tick(5);
    chk("rst_addr", {16'd0, reg_addr}, 32'd0);
    chk("rst_wdata", {24'd0, reg_wdata}, 32'd0);
    chk("rst_we", {31'd0, reg_we}, 32'd0);
    chk("rst_re", {31'd0, reg_re}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sda", {31'd0, sda_bus}, 32'd1);
    s_rst_n = 1'b1;
    tick(5);

    // Single register write
    wbuf = '{8'h82};
    wr_txn(16'h3008);
    check_logs("w_single");

    // Burst write with auto-increment
    wbuf = '{8'h11, 8'h22};
    wr_txn(16'h3800);
    check_logs("w_burst");

    // Address set, STOP, then single-byte read
    wbuf.delete();
    wr_txn(16'h300A);
    rd_txn(1);
    check_logs("rd_single");

    // Foreign device address: never ACKed, nothing strobed
    i2c_start();
    send_chk("ack_bad", 8'h7A, 1'b1);
    send_chk("ack_bad2", 8'h30, 1'b1);
    send_chk("ack_bad3", 8'h55, 1'b1);
    i2c_stop();
    chk("bad_busy", {31'd0, busy}, 32'd0);
    check_logs("bad_dev");

    // STOP in the middle of a data byte
    i2c_start();
    send_chk("ack_pd", 8'h78, 1'b0);
    send_chk("ack_pah", 8'h30, 1'b0);
    send_chk("ack_pal", 8'h20, 1'b0);
    mdl_ptr = 16'h3020;
    wr_bit(1'b1); wr_bit(1'b0); wr_bit(1'b1); wr_bit(1'b0);
    i2c_stop();
    chk("part_busy", {31'd0, busy}, 32'd0);
    check_logs("partial");
    wbuf = '{8'hA7};
    wr_txn(16'h3021);
    wbuf.delete();
    wr_txn(16'h3021);
    rd_txn(1);
    check_logs("after_part");

    // Pointer wrap on write and on read
    wbuf = '{8'($urandom), 8'($urandom)};
    wr_txn(16'hFFFF);
    check_logs("wrap_w");
    wbuf.delete();
    wr_txn(16'hFFFF);
    rd_txn(2);
    check_logs("wrap_r");

    // Randomised mix of writes and reads at varying SCL rates
    for (int k = 0; k < 10; k++) begin
      h = $urandom_range(8, 12);
      wbuf.delete();
      if ($urandom_range(0, 1) == 0) begin
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) wbuf.push_back(8'($urandom));
        wr_txn(16'($urandom));
      end else begin
        if ($urandom_range(0, 1) == 1) wr_txn(16'($urandom));
        rd_txn($urandom_range(1, 3));
      end
      check_logs("rnd");
    end
    h = 10;

    // Reset while the slave holds the address ACK
    dev_w = 8'h78;
    i2c_start();
    for (int i = 7; i >= 0; i--) wr_bit(dev_w[i]);
    m_sda = 1'b1;
    tick(3);
    chk("ack_held", {31'd0, sda_bus}, 32'd0);
    #2 s_rst_n = 1'b0;
    #1;
    chk("rst_mid_sda", {31'd0, sda_bus}, 32'd1);
    chk("rst_mid_addr", {16'd0, reg_addr}, 32'd0);
    chk("rst_mid_we", {31'd0, reg_we}, 32'd0);
    chk("rst_mid_re", {31'd0, reg_re}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    mdl_ptr = 16'h0000;
    tick(3);
    s_rst_n = 1'b1;
    tick(2);
    scl = 1'b1; tick(h);
    scl = 1'b0; tick(h / 2);
    send_chk("ack_norst1", 8'h30, 1'b1);
    send_chk("ack_norst2", 8'h08, 1'b1);
    send_chk("ack_norst3", 8'h99, 1'b1);
    i2c_stop();
    check_logs("after_rst");

    // Normal operation resumes with a new START
    wbuf = '{8'h3C};
    wr_txn(16'h1234);
    check_logs("recover");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
